// File: rtl/rf_bank.sv
// Parametrised flop-based register file with registered read ports, a flat
// all-register view, direct writes and a valid/ready burst-load engine.
module rf_bank #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned NUM_RD     = 2
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           wr_drop,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] rf_flat,
  input  logic                           ld_start,
  input  logic [ADDR_WIDTH-1:0]          ld_base,
  input  logic [ADDR_WIDTH:0]            ld_count,
  input  logic                           ld_valid,
  input  logic [DATA_WIDTH-1:0]          ld_data,
  output logic                           ld_ready,
  output logic                           ld_busy,
  output logic                           ld_done,
  output logic                           ld_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  localparam logic [ADDR_WIDTH:0]   NREGS_C = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH:0]   ONE_C   = (ADDR_WIDTH+1)'(1);

  state_e                                state_q, state_d;
  logic [ADDR_WIDTH-1:0]                 ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]                   rem_q, rem_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   regs_q, regs_d;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]     rd_q, rd_d;
  logic                                  drop_q, drop_d;
  logic                                  err_q, err_d;
  logic                                  beat;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    err_d   = 1'b0;
    beat    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          if ({1'b0, ld_base} >= NREGS_C || ld_count > NREGS_C) begin
            err_d = 1'b1;
          end else if (ld_count == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            ptr_d   = ld_base;
            rem_d   = ld_count;
          end
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          beat  = 1'b1;
          ptr_d = (ptr_q == LAST_C) ? '0 : ptr_q + 1'b1;
          rem_d = rem_q - ONE_C;
          if (rem_q == ONE_C) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A load beat owns the write port that cycle; any direct write is dropped.
  always_comb begin
    regs_d = regs_q;
    drop_d = wr_en && (({1'b0, wr_addr} >= NREGS_C) || beat);
    for (int k = 0; k < NUM_REGS; k++) begin
      if (beat && ptr_q == ADDR_WIDTH'(k)) begin
        regs_d[k] = ld_data;
      end else if (wr_en && !beat && wr_addr == ADDR_WIDTH'(k)) begin
        regs_d[k] = wr_data;
      end
    end
  end

  // Reads sample the next-state array so a same-cycle write is visible.
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(k)) rd_d[i] = regs_d[k];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      // NOTE: the register array is small and flop-based, and consumers read
      // rf_flat straight after reset, so it is cleared like any other state.
      regs_q  <= '0;
      rd_q    <= '0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      regs_q  <= regs_d;
      rd_q    <= rd_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  assign rf_flat  = regs_q;
  assign rd_data  = rd_q;
  assign wr_drop  = drop_q;
  assign ld_err   = err_q;
  assign ld_ready = (state_q == S_LOAD);
  assign ld_busy  = (state_q != S_IDLE);
  assign ld_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_rf_bank.sv
// Directed bench for rf_bank with a 5-entry bank, exercising wrap at a
// non-power-of-two depth and out-of-range addresses.
module tb_rf_bank;

  localparam int DW = 16;
  localparam int NR = 5;
  localparam int AW = 3;
  localparam int RD = 2;

  logic               clk = 1'b0;
  logic               resetn;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic               wr_drop;
  logic [RD*AW-1:0]   rd_addr;
  logic [RD*DW-1:0]   rd_data;
  logic [NR*DW-1:0]   rf_flat;
  logic               ld_start;
  logic [AW-1:0]      ld_base;
  logic [AW:0]        ld_count;
  logic               ld_valid;
  logic [DW-1:0]      ld_data;
  logic               ld_ready, ld_busy, ld_done, ld_err;

  logic [NR-1:0][DW-1:0] exp_regs;
  int n_cmp = 0;
  int n_bad = 0;

  // status = {busy, ready, done, err, drop}
  logic [4:0] status;
  assign status = {ld_busy, ld_ready, ld_done, ld_err, wr_drop};

  rf_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .NUM_RD(RD)) dut (
    .clk(clk), .resetn(resetn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
    .rd_addr(rd_addr), .rd_data(rd_data), .rf_flat(rf_flat),
    .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    ld_start = 0; ld_base = '0; ld_count = '0; ld_valid = 0; ld_data = '0;
  endtask

  task automatic cmp_status(input string name, input logic [4:0] exp);
    n_cmp++;
    if (status !== exp) begin
      n_bad++;
      $display("FAIL %s status{busy,ready,done,err,drop}: got %b expected %b", name, status, exp);
    end
  endtask

  task automatic cmp_regs(input string name);
    n_cmp++;
    if (rf_flat !== exp_regs) begin
      n_bad++;
      $display("FAIL %s rf_flat: got %h expected %h", name, rf_flat, exp_regs);
    end
  endtask

  task automatic test_reset();
    resetn   = 0;
    wr_en    = 1'($urandom);  wr_addr  = AW'($urandom); wr_data = DW'($urandom);
    rd_addr  = (RD*AW)'($urandom);
    ld_start = 1'($urandom);  ld_base  = AW'($urandom); ld_count = (AW+1)'($urandom);
    ld_valid = 1'($urandom);  ld_data  = DW'($urandom);
    step(); step();
    exp_regs = '0;
    cmp_regs("reset");
    n_cmp++;
    if (rd_data !== '0) begin
      n_bad++; $display("FAIL reset rd_data: got %h expected 0", rd_data);
    end
    cmp_status("reset", 5'b00000);
    idle_inputs();
    resetn = 1;
    step();
    cmp_status("reset_release", 5'b00000);
  endtask

  task automatic test_direct();
    wr_en = 1; wr_addr = 3'd2; wr_data = 16'h1234; rd_addr = {3'd0, 3'd2};
    step();
    exp_regs[2] = 16'h1234;
    n_cmp++;
    if (rd_data[15:0] !== 16'h1234) begin
      n_bad++; $display("FAIL direct_rd0 write-first: got %h expected 1234", rd_data[15:0]);
    end
    n_cmp++;
    if (rf_flat[47:32] !== 16'h1234) begin
      n_bad++; $display("FAIL direct_flat reg2: got %h expected 1234", rf_flat[47:32]);
    end
    cmp_status("direct_ok", 5'b00000);
    wr_addr = 3'd5; wr_data = 16'hFFFF; rd_addr = {3'd2, 3'd6};
    step();
    cmp_status("direct_oor5", 5'b00001);
    cmp_regs("direct_oor5");
    n_cmp++;
    if (rd_data !== {16'h1234, 16'h0000}) begin
      n_bad++; $display("FAIL direct_rd oor/port1: got %h expected 12340000", rd_data);
    end
    wr_addr = 3'd7;
    step();
    cmp_status("direct_oor7", 5'b00001);
    cmp_regs("direct_oor7");
    wr_en = 0;
    step();
    cmp_status("direct_drop_clear", 5'b00000);
  endtask

  task automatic test_wrapped_burst();
    ld_start = 1; ld_base = 3'd3; ld_count = 4'd3;
    step();
    ld_start = 0;
    cmp_status("burst_start", 5'b11000);
    ld_valid = 1; ld_data = 16'h000A; step();
    ld_valid = 0; step();
    ld_valid = 1; ld_data = 16'h000B; rd_addr = {3'd4, 3'd0}; step();
    n_cmp++;
    if (rd_data[31:16] !== 16'h000B) begin
      n_bad++; $display("FAIL burst_rd1 write-first: got %h expected 000b", rd_data[31:16]);
    end
    ld_valid = 0; step();
    cmp_status("burst_gap", 5'b11000);
    ld_valid = 1; ld_data = 16'h000C; step();
    ld_valid = 0;
    cmp_status("burst_done", 5'b10100);
    exp_regs[3] = 16'h000A; exp_regs[4] = 16'h000B; exp_regs[0] = 16'h000C;
    cmp_regs("burst_wrap");
    step();
    cmp_status("burst_idle", 5'b00000);
  endtask

  task automatic test_collision();
    ld_start = 1; ld_base = 3'd0; ld_count = 4'd3; step();
    ld_start = 0;
    ld_valid = 1; ld_data = 16'h0011; step();
    ld_data = 16'h0055; wr_en = 1; wr_addr = 3'd1; wr_data = 16'h0077; step();
    exp_regs[0] = 16'h0011; exp_regs[1] = 16'h0055;
    cmp_status("collide_same", 5'b11001);
    cmp_regs("collide_same");
    ld_valid = 0; wr_addr = 3'd2; wr_data = 16'h0099; step();
    exp_regs[2] = 16'h0099;
    cmp_status("stall_write", 5'b11000);
    cmp_regs("stall_write");
    wr_en = 0; ld_valid = 1; ld_data = 16'h0066; step();
    ld_valid = 0;
    exp_regs[2] = 16'h0066;
    cmp_status("collide_done", 5'b10100);
    cmp_regs("collide_done");
    step();
  endtask

  task automatic test_rejects();
    ld_start = 1; ld_base = 3'd1; ld_count = 4'd0; step();
    ld_start = 0;
    cmp_status("count0_done", 5'b10100);
    step();
    cmp_status("count0_idle", 5'b00000);
    cmp_regs("count0_nowrite");
    ld_start = 1; ld_base = 3'd5; ld_count = 4'd1; step();
    ld_start = 0;
    cmp_status("base_oor_err", 5'b00010);
    step();
    cmp_status("base_oor_clear", 5'b00000);
    ld_start = 1; ld_base = 3'd0; ld_count = 4'd6; step();
    ld_start = 0;
    cmp_status("count_oor_err", 5'b00010);
    cmp_regs("count_oor_nowrite");
    step();
    ld_start = 1; ld_base = 3'd0; ld_count = 4'd2; step();
    ld_start = 0;
    ld_valid = 1; ld_data = 16'h0021; step();
    ld_valid = 0; ld_start = 1; ld_base = 3'd3; ld_count = 4'd1; step();
    ld_start = 0;
    cmp_status("start_in_load", 5'b11000);
    ld_valid = 1; ld_data = 16'h0022; step();
    ld_valid = 0;
    exp_regs[0] = 16'h0021; exp_regs[1] = 16'h0022;
    cmp_status("start_in_load_done", 5'b10100);
    cmp_regs("start_in_load_regs");
    step();
  endtask

  task automatic test_reset_mid_burst();
    ld_start = 1; ld_base = 3'd0; ld_count = 4'd4; step();
    ld_start = 0;
    ld_valid = 1; ld_data = 16'h0031; step();
    ld_data = 16'h0032; step();
    ld_valid = 0; resetn = 0; step();
    exp_regs = '0;
    cmp_regs("midrst_regs");
    cmp_status("midrst", 5'b00000);
    n_cmp++;
    if (rd_data !== '0) begin
      n_bad++; $display("FAIL midrst rd_data: got %h expected 0", rd_data);
    end
    resetn = 1; step();
    cmp_status("midrst_no_done", 5'b00000);
    ld_start = 1; ld_base = 3'd4; ld_count = 4'd2; step();
    ld_start = 0;
    ld_valid = 1; ld_data = 16'h0041; step();
    ld_data = 16'h0042; step();
    ld_valid = 0;
    exp_regs[4] = 16'h0041; exp_regs[0] = 16'h0042;
    cmp_status("fresh_done", 5'b10100);
    cmp_regs("fresh_regs");
    step();
    cmp_status("fresh_idle", 5'b00000);
  endtask

  initial begin
    idle_inputs();
    exp_regs = '0;
    test_reset();
    test_direct();
    test_wrapped_burst();
    test_collision();
    test_rejects();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
